map_port_arbiter: RTL and testbench
===================================

MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 1: clocks from mem_addr presented to mem_data valid, legal range 1..4.
REQ-002 Parameter STARVE_LIMIT, default 2048: maximum cycles a pending bot request waits behind video, legal range 1..4095.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vid_req  in  1  video read wanted this cycle (driven from video_on).
REQ-006 vid_addr  in  14  video map address {world_row[6:0], world_column[6:0]}.
REQ-007 vid_data  out  2  registered map data for video.
REQ-008 vid_valid  out  1  vid_data holds a fresh read result this cycle.
REQ-009 bot_req  in  1  bot map-lookup request, sampled when bot_busy is low.
REQ-010 bot_addr  in  14  bot lookup address {row, column}, captured with bot_req.
REQ-011 bot_busy  out  1  a bot request is accepted and not yet acknowledged.
REQ-012 bot_ack  out  1  one-cycle pulse; bot_data valid.
REQ-013 bot_data  out  2  registered map data for bot; holds until next bot_ack.
REQ-014 mem_addr  out  14  combinational address to the single-port world-map memory.
REQ-015 mem_data  in  2  memory read data, MEM_LATENCY cycles after mem_addr.

Function
REQ-016 Bot side SHALL be an FSM with states IDLE, PENDING, INFLIGHT.
REQ-017 IDLE: bot_req=1 SHALL latch bot_addr, enter PENDING, and raise bot_busy on the next cycle.
REQ-018 PENDING: the bot SHALL be granted in a cycle where vid_req=0 or wait_cnt==STARVE_LIMIT; on grant the FSM enters INFLIGHT.
REQ-019 Otherwise, with vid_req=1, video SHALL be granted; with neither, no grant, and mem_addr holds its last value.
REQ-020 mem_addr SHALL equal the granted owner's address in the grant cycle: latched bot address or vid_addr.
REQ-021 wait_cnt (12 bits) SHALL increment each PENDING cycle with vid_req=1, saturate at STARVE_LIMIT, and clear on bot grant.
REQ-022 Each grant SHALL push an owner tag (NONE/VID/BOT) into a MEM_LATENCY-deep tag pipeline, one entry per cycle.
REQ-023 Tag VID at pipeline exit: vid_data <= mem_data and vid_valid=1 on the next cycle, so total video latency is MEM_LATENCY+1 clocks.
REQ-024 Tag BOT at exit: bot_data <= mem_data, bot_ack pulses for 1 cycle, FSM returns to IDLE, and bot_busy falls in the same cycle as bot_ack.
REQ-025 Tag NONE, or a stolen video slot: vid_valid=0 and vid_data holds its previous value, giving a stretched pixel.
REQ-026 A bot_req while bot_busy=1 SHALL be ignored, with no queueing.
REQ-027 A bot_req in the same cycle as bot_ack SHALL be ignored; acceptance is possible from the following cycle.
REQ-028 A forced grant (wait_cnt==STARVE_LIMIT) SHALL take exactly one cycle from video.
REQ-029 At most one bot read SHALL be in flight at any time.

Reset
REQ-030 On reset the FSM SHALL go to IDLE, wait_cnt and the tag pipeline to zero/NONE, and latched address to 0.
REQ-031 Reset values: vid_data=0, vid_valid=0, bot_data=0, bot_ack=0, bot_busy=0, mem_addr=0.
REQ-032 A read in flight during reset SHALL be discarded; no bot_ack is produced for it after reset.

Structure
REQ-033 Package map_arb_pkg SHALL hold MAP_ADDR_W=14, MAP_DATA_W=2, the bot FSM state encoding, and the tag encoding (NONE=0, VID=1, BOT=2).
REQ-034 The tag pipeline SHALL be the sub-module map_arb_tag_pipe, parameterised by MEM_LATENCY and reset to NONE.

Verification
REQ-035 With vid_req=1 steady, vid_addr=0x0085 and memory data 2'b10: vid_data=2'b10 and vid_valid=1 exactly 2 clocks later (MEM_LATENCY=1).
REQ-036 With bot_req at addr 0x1FFF and vid_req=0: bot_busy=1 next cycle, bot_ack at the 3rd cycle with mem[0x1FFF], then bot_busy=0.
REQ-037 With vid_req=1 continuously and STARVE_LIMIT=8: bot grant after 8 waiting cycles; that video slot has vid_valid=0 and vid_data unchanged; video resumes the next cycle.
REQ-038 With vid_req dropping for 1 cycle (blanking) while the bot is pending: the bot is granted in that cycle, wait_cnt clears, and no video slot is lost.
REQ-039 With bot_req pulsed every cycle for 20 cycles: exactly one ack per accept, and requests during busy and in the bot_ack cycle are dropped.
REQ-040 With reset asserted one cycle after a bot grant: no bot_ack, all outputs 0, and a fresh request afterwards completes normally.

Source files
------------

// File: rtl/map_arb_pkg.sv
// Shared widths, bot FSM states and owner tags for the world-map port arbiter.
package map_arb_pkg;

    localparam int unsigned MAP_ADDR_W = 14;
    localparam int unsigned MAP_DATA_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_INFLIGHT = 2'd2
    } bot_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_BOT  = 2'd2
    } tag_t;

endpackage

// File: rtl/map_arb_tag_pipe.sv
// Owner-tag delay line that tracks which requester each memory read belongs to.
module map_arb_tag_pipe
    import map_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    localparam int unsigned W = 2 * MEM_LATENCY;

    logic [W-1:0] stage;

    if (MEM_LATENCY == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (reset) stage <= '0;
            else       stage <= tag_in;
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (reset) stage <= '0;
            else       stage <= {stage[W-3:0], tag_in};
        end
    end

    assign tag_out = tag_t'(stage[W-1 -: 2]);

endmodule

// File: rtl/map_port_arbiter.sv
// Shares one single-port world-map memory between video reads and bot lookups,
// with video priority and a bounded starvation wait for the bot.
module map_port_arbiter
    import map_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [MAP_ADDR_W-1:0] vid_addr,
    output logic [MAP_DATA_W-1:0] vid_data,
    output logic                  vid_valid,
    input  logic                  bot_req,
    input  logic [MAP_ADDR_W-1:0] bot_addr,
    output logic                  bot_busy,
    output logic                  bot_ack,
    output logic [MAP_DATA_W-1:0] bot_data,
    output logic [MAP_ADDR_W-1:0] mem_addr,
    input  logic [MAP_DATA_W-1:0] mem_data
);

    localparam logic [11:0] LIMIT = 12'(STARVE_LIMIT);

    bot_state_t            state, state_next;
    logic [MAP_ADDR_W-1:0] bot_addr_q;
    logic [MAP_ADDR_W-1:0] last_addr;
    logic [11:0]           wait_cnt;
    logic                  accept, grant_bot, grant_vid;
    tag_t                  tag_in, tag_out;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        grant_bot  = 1'b0;
        grant_vid  = 1'b0;
        case (state)
            ST_IDLE: begin
                grant_vid = vid_req;
                // The ack cycle is already IDLE, so block re-acceptance explicitly.
                if (bot_req && !bot_ack) begin
                    accept     = 1'b1;
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!vid_req || wait_cnt == LIMIT) begin
                    grant_bot  = 1'b1;
                    state_next = ST_INFLIGHT;
                end else begin
                    grant_vid = 1'b1;
                end
            end
            ST_INFLIGHT: begin
                grant_vid = vid_req;
                if (tag_out == TAG_BOT) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        if (grant_bot)      mem_addr = bot_addr_q;
        else if (grant_vid) mem_addr = vid_addr;
        else                mem_addr = last_addr;

        if (grant_bot)      tag_in = TAG_BOT;
        else if (grant_vid) tag_in = TAG_VID;
        else                tag_in = TAG_NONE;
    end

    assign bot_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            bot_addr_q <= '0;
            last_addr  <= '0;
            wait_cnt   <= '0;
            vid_data   <= '0;
            vid_valid  <= 1'b0;
            bot_data   <= '0;
            bot_ack    <= 1'b0;
        end else begin
            state     <= state_next;
            last_addr <= mem_addr;
            if (accept) bot_addr_q <= bot_addr;

            if (grant_bot)
                wait_cnt <= '0;
            else if (state == ST_PENDING && vid_req && wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + 12'd1;

            vid_valid <= (tag_out == TAG_VID);
            if (tag_out == TAG_VID) vid_data <= mem_data;
            bot_ack   <= (tag_out == TAG_BOT);
            if (tag_out == TAG_BOT) bot_data <= mem_data;
        end
    end

    map_arb_tag_pipe #(
        .MEM_LATENCY(MEM_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

endmodule

// File: tb/tb_map_port_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for map_port_arbiter.
module tb_map_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic [1:0]  vid_data;
    logic        vid_valid;
    logic        bot_req;
    logic [13:0] bot_addr;
    logic        bot_busy;
    logic        bot_ack;
    logic [1:0]  bot_data;
    logic [13:0] mem_addr;
    logic [1:0]  mem_data = 2'b00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    map_port_arbiter #(
        .MEM_LATENCY (1),
        .STARVE_LIMIT(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_data (vid_data),
        .vid_valid(vid_valid),
        .bot_req  (bot_req),
        .bot_addr (bot_addr),
        .bot_busy (bot_busy),
        .bot_ack  (bot_ack),
        .bot_data (bot_data),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    function automatic logic [1:0] memf(input logic [13:0] a);
        return a[1:0] ^ a[3:2] ^ a[7:6];
    endfunction

    // One-cycle registered memory read
    always @(posedge clk) mem_data <= memf(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        vreq;
        logic [13:0] vaddr;
        logic        breq;
        logic [13:0] baddr;
        logic        e_vvalid;
        logic [1:0]  e_vdata;
        logic        e_busy;
        logic        e_ack;
        logic [1:0]  e_bdata;
        logic [13:0] e_maddr;
    } vec_t;

    vec_t vecs[10];
    int   acks;
    logic [13:0] exp_ma;

    initial begin
        vecs[0] = '{1'b1, 14'h0085, 1'b0, 14'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 14'h0085};
        vecs[1] = '{1'b1, 14'h0085, 1'b0, 14'h0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 14'h0085};
        vecs[2] = '{1'b1, 14'h0123, 1'b0, 14'h0000, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 14'h0123};
        vecs[3] = '{1'b0, 14'h0123, 1'b0, 14'h0000, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 14'h0123};
        vecs[4] = '{1'b0, 14'h0123, 1'b0, 14'h0000, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 14'h0123};
        vecs[5] = '{1'b0, 14'h0123, 1'b1, 14'h1FFF, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 14'h0123};
        vecs[6] = '{1'b0, 14'h0123, 1'b0, 14'h1FFF, 1'b0, 2'd3, 1'b1, 1'b0, 2'd0, 14'h1FFF};
        vecs[7] = '{1'b0, 14'h0123, 1'b1, 14'h0001, 1'b0, 2'd3, 1'b1, 1'b0, 2'd0, 14'h1FFF};
        vecs[8] = '{1'b0, 14'h0123, 1'b1, 14'h0002, 1'b0, 2'd3, 1'b0, 1'b1, 2'd3, 14'h1FFF};
        vecs[9] = '{1'b0, 14'h0123, 1'b0, 14'h0002, 1'b0, 2'd3, 1'b0, 1'b0, 2'd3, 14'h1FFF};

        reset = 1'b1; vid_req = 1'b0; vid_addr = '0; bot_req = 1'b0; bot_addr = '0;
        repeat (3) tick();
        check("rst_vid_valid", 32'(vid_valid), 0);
        check("rst_vid_data",  32'(vid_data),  0);
        check("rst_bot_busy",  32'(bot_busy),  0);
        check("rst_bot_ack",   32'(bot_ack),   0);
        check("rst_bot_data",  32'(bot_data),  0);
        check("rst_mem_addr",  32'(mem_addr),  0);

        // Basic video latency, hold on idle, and a single bot lookup
        for (int i = 0; i < 10; i++) begin
            tick();
            reset    = 1'b0;
            vid_req  = vecs[i].vreq;
            vid_addr = vecs[i].vaddr;
            bot_req  = vecs[i].breq;
            bot_addr = vecs[i].baddr;
            #1;
            check($sformatf("vec%0d_vid_valid", i), 32'(vid_valid), 32'(vecs[i].e_vvalid));
            check($sformatf("vec%0d_vid_data", i),  32'(vid_data),  32'(vecs[i].e_vdata));
            check($sformatf("vec%0d_bot_busy", i),  32'(bot_busy),  32'(vecs[i].e_busy));
            check($sformatf("vec%0d_bot_ack", i),   32'(bot_ack),   32'(vecs[i].e_ack));
            check($sformatf("vec%0d_bot_data", i),  32'(bot_data),  32'(vecs[i].e_bdata));
            check($sformatf("vec%0d_mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_maddr));
        end

        // Starvation: continuous video, forced bot grant after 8 waiting cycles
        for (int k = 0; k < 13; k++) begin
            tick();
            vid_req  = 1'b1;
            vid_addr = 14'h0100 + 14'(k);
            bot_req  = (k == 0);
            bot_addr = 14'h0006;
            #1;
            if (k == 1) check("starve_busy", 32'(bot_busy), 1);
            if (k >= 1 && k <= 8) check($sformatf("starve_vid_grant%0d", k), 32'(mem_addr), 32'(14'h0100 + 14'(k)));
            if (k == 9) check("starve_bot_grant", 32'(mem_addr), 32'h0006);
            if (k == 10) begin
                check("starve_vid_resume", 32'(mem_addr), 32'h010A);
                check("starve_pre_valid", 32'(vid_valid), 1);
                check("starve_pre_data",  32'(vid_data), 32'(2'b10));
            end
            if (k == 11) begin
                check("starve_ack",        32'(bot_ack),   1);
                check("starve_bot_data",   32'(bot_data),  32'(memf(14'h0006)));
                check("starve_busy_fall",  32'(bot_busy),  0);
                check("starve_slot_valid", 32'(vid_valid), 0);
                check("starve_slot_data",  32'(vid_data),  32'(2'b10));
            end
            if (k == 12) begin
                check("starve_post_valid", 32'(vid_valid), 1);
                check("starve_post_data",  32'(vid_data),  32'(2'b00));
            end
        end

        // Blanking grants the bot early; a second request must wait the full limit again
        for (int k = 0; k < 20; k++) begin
            tick();
            vid_req  = (k != 4);
            vid_addr = 14'h0200 + 14'(k);
            bot_req  = (k == 0 || k == 7);
            bot_addr = (k < 7) ? 14'h0006 : 14'h000A;
            #1;
            if (k == 4)       exp_ma = 14'h0006;
            else if (k == 16) exp_ma = 14'h000A;
            else              exp_ma = 14'h0200 + 14'(k);
            check($sformatf("blank_mem_addr%0d", k), 32'(mem_addr), 32'(exp_ma));
            if (k == 5) check("blank_busy_inflight", 32'(bot_busy), 1);
            if (k == 6) begin
                check("blank_ack",  32'(bot_ack),  1);
                check("blank_data", 32'(bot_data), 32'(memf(14'h0006)));
            end
            if (k == 7) check("blank_busy_idle", 32'(bot_busy), 0);
            if (k == 8) check("blank_busy_again", 32'(bot_busy), 1);
            if (k == 18) begin
                check("blank_ack2",  32'(bot_ack),  1);
                check("blank_data2", 32'(bot_data), 32'(memf(14'h000A)));
            end
        end

        // bot_req held high: accepts only when idle and not in the ack cycle
        acks = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            vid_req  = 1'b0;
            bot_req  = (k < 20);
            bot_addr = 14'(k) + 14'd1;
            #1;
            check($sformatf("pulse_busy%0d", k), 32'(bot_busy),
                  32'((k < 20) && (k % 4 == 1 || k % 4 == 2)));
            check($sformatf("pulse_ack%0d", k), 32'(bot_ack), 32'((k < 20) && (k % 4 == 3)));
            if (bot_ack) acks++;
            if (k < 20 && k % 4 == 1) check($sformatf("pulse_grant_addr%0d", k), 32'(mem_addr), 32'(k));
            if (k < 20 && k % 4 == 3) check($sformatf("pulse_data%0d", k), 32'(bot_data), 32'(memf(14'(k - 2))));
        end
        check("pulse_ack_count", 32'(acks), 5);

        // Reset one cycle after a bot grant discards the read
        tick(); bot_req = 1'b1; bot_addr = 14'h0033; #1;
        tick(); bot_req = 1'b0; #1;
        check("rstfl_grant_addr", 32'(mem_addr), 32'h0033);
        tick(); reset = 1'b1; #1;
        tick(); reset = 1'b0; #1;
        check("rstfl_vid_valid", 32'(vid_valid), 0);
        check("rstfl_vid_data",  32'(vid_data),  0);
        check("rstfl_bot_busy",  32'(bot_busy),  0);
        check("rstfl_bot_ack",   32'(bot_ack),   0);
        check("rstfl_bot_data",  32'(bot_data),  0);
        check("rstfl_mem_addr",  32'(mem_addr),  0);
        tick(); bot_req = 1'b1; bot_addr = 14'h1FFF; #1;
        check("rstfl_no_late_ack", 32'(bot_ack), 0);
        tick(); bot_req = 1'b0; #1;
        check("rstfl_fresh_busy", 32'(bot_busy), 1);
        check("rstfl_fresh_addr", 32'(mem_addr), 32'h1FFF);
        tick();
        tick(); #1;
        check("rstfl_fresh_ack",  32'(bot_ack),  1);
        check("rstfl_fresh_data", 32'(bot_data), 32'(memf(14'h1FFF)));
        check("rstfl_fresh_idle", 32'(bot_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
